// File: rtl/port_out_mux.sv
// Registered output-port mux: locks onto a one-hot granted input for one packet.
// Optional completed-packet counter on pkt_cnt when PKT_CNT_EN is defined.
//
// state | meaning
// IDLE  | no grant held, outputs idle, watching grant
// ARMED | grant latched into src_id, waiting for frame start on that channel
// PASS  | forwarding channel src_id every cycle until its last beat
module port_out_mux #(
    parameter int N_IN    = 16,
    parameter int DATA_W  = 1,
    parameter int TIMEOUT = 64,
    parameter int SEL_W   = $clog2(N_IN)
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [N_IN-1:0]          frame_n,
    input  logic [N_IN-1:0]          valid_n,
    input  logic [N_IN*DATA_W-1:0]   din,
    input  logic [N_IN-1:0]          grant,
    output logic                     frame_o,
    output logic                     valid_o,
    output logic [DATA_W-1:0]        dout,
    output logic                     busy,
    output logic [SEL_W-1:0]         src_id,
    output logic                     grant_err,
    output logic                     timeout
`ifdef PKT_CNT_EN
    ,
    output logic [15:0]              pkt_cnt
`endif
);

    localparam int CNT_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ARMED, PASS} state_t;

    state_t            state;
    logic [CNT_W-1:0]  wait_cnt;
    logic              gnt_any;
    logic              gnt_onehot;
    logic [SEL_W-1:0]  gnt_idx;
    logic              sel_frame;
    logic              sel_valid;
    logic [DATA_W-1:0] sel_data;

    assign gnt_any    = |grant;
    assign gnt_onehot = $onehot(grant);
    assign busy       = (state != IDLE);

    // OR-encoding of the grant is only meaningful when the grant is one-hot
    always_comb begin
        gnt_idx   = '0;
        sel_frame = 1'b1;
        sel_valid = 1'b1;
        sel_data  = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (grant[i])
                gnt_idx = gnt_idx | SEL_W'(i);
            if (src_id == SEL_W'(i)) begin
                sel_frame = frame_n[i];
                sel_valid = valid_n[i];
                sel_data  = din[i*DATA_W +: DATA_W];
            end
        end
    end

    // wait_cnt counts down from TIMEOUT-1; reaching zero while still armed is the timeout
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state     <= IDLE;
            src_id    <= '0;
            wait_cnt  <= '0;
            frame_o   <= 1'b1;
            valid_o   <= 1'b1;
            dout      <= '0;
            grant_err <= 1'b0;
            timeout   <= 1'b0;
`ifdef PKT_CNT_EN
            pkt_cnt   <= 16'd0;
`endif
        end else begin
            grant_err <= 1'b0;
            timeout   <= 1'b0;
            case (state)
                IDLE: begin
                    frame_o <= 1'b1;
                    valid_o <= 1'b1;
                    dout    <= '0;
                    src_id  <= '0;
                    if (gnt_onehot) begin
                        src_id   <= gnt_idx;
                        wait_cnt <= CNT_W'(TIMEOUT - 1);
                        state    <= ARMED;
                    end else if (gnt_any) begin
                        grant_err <= 1'b1;
                    end
                end
                ARMED: begin
                    if (!sel_frame) begin
                        frame_o <= sel_frame;
                        valid_o <= sel_valid;
                        dout    <= sel_data;
                        state   <= PASS;
                    end else begin
                        frame_o <= 1'b1;
                        valid_o <= 1'b1;
                        dout    <= '0;
                        if (!gnt_any) begin
                            state  <= IDLE;
                            src_id <= '0;
                        end else if (wait_cnt == '0) begin
                            timeout <= 1'b1;
                            state   <= IDLE;
                            src_id  <= '0;
                        end else begin
                            wait_cnt <= wait_cnt - CNT_W'(1);
                        end
                    end
                end
                PASS: begin
                    frame_o <= sel_frame;
                    valid_o <= sel_valid;
                    dout    <= sel_data;
                    if (sel_frame) begin
                        state  <= IDLE;
                        src_id <= '0;
`ifdef PKT_CNT_EN
                        pkt_cnt <= pkt_cnt + 16'd1;
`endif
                    end
                end
                default: begin
                    state  <= IDLE;
                    src_id <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_port_out_mux.sv
// Self-checking bench for port_out_mux: directed vector table, corner sequences,
// then randomized traffic against a behavioural reference model.
module tb_port_out_mux;

    localparam int N  = 16;
    localparam int DW = 1;
    localparam int TO = 8;
    localparam int SW = 4;

    logic          clock = 1'b0;
    logic          reset_n;
    logic [N-1:0]  frame_n, valid_n, grant;
    logic [N-1:0]  din;
    logic          frame_o, valid_o, busy, grant_err, timeout;
    logic [DW-1:0] dout;
    logic [SW-1:0] src_id;
`ifdef PKT_CNT_EN
    logic [15:0]   pkt_cnt;
`endif

    port_out_mux #(.N_IN(N), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clock(clock), .reset_n(reset_n), .frame_n(frame_n), .valid_n(valid_n),
        .din(din), .grant(grant), .frame_o(frame_o), .valid_o(valid_o),
        .dout(dout), .busy(busy), .src_id(src_id), .grant_err(grant_err),
        .timeout(timeout)
`ifdef PKT_CNT_EN
        , .pkt_cnt(pkt_cnt)
`endif
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a held grant, whether a packet is in flight, and cycles waited
    bit          m_held, m_in_pkt;
    int          m_src, m_waited;
    logic        m_frame, m_valid, m_dout, m_err, m_to;
    logic [15:0] m_cnt;

    task automatic model_step();
        m_err = 1'b0;
        m_to  = 1'b0;
        if (!reset_n) begin
            m_held = 0; m_in_pkt = 0; m_src = 0; m_waited = 0;
            m_frame = 1; m_valid = 1; m_dout = 0; m_cnt = 0;
        end else if (!m_held) begin
            m_frame = 1; m_valid = 1; m_dout = 0;
            if ($countones(grant) == 1) begin
                for (int i = 0; i < N; i++) if (grant[i]) m_src = i;
                m_held = 1; m_waited = 0;
            end else if (grant != 0) begin
                m_err = 1'b1;
            end
        end else if (!m_in_pkt) begin
            if (frame_n[m_src] == 1'b0) begin
                m_frame = frame_n[m_src]; m_valid = valid_n[m_src]; m_dout = din[m_src];
                m_in_pkt = 1;
            end else begin
                m_frame = 1; m_valid = 1; m_dout = 0;
                if (grant == 0) begin
                    m_held = 0; m_src = 0;
                end else if (m_waited == TO - 1) begin
                    m_to = 1'b1; m_held = 0; m_src = 0;
                end else begin
                    m_waited++;
                end
            end
        end else begin
            m_frame = frame_n[m_src]; m_valid = valid_n[m_src]; m_dout = din[m_src];
            if (frame_n[m_src]) begin
                m_in_pkt = 0; m_held = 0; m_src = 0; m_cnt = m_cnt + 16'd1;
            end
        end
    endtask

    task automatic cyc();
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic cmp_model(input string tag);
        chk({tag, "_frame"}, frame_o, m_frame);
        chk({tag, "_valid"}, valid_o, m_valid);
        chk({tag, "_dout"}, dout, m_dout);
        chk({tag, "_busy"}, busy, m_held);
        chk({tag, "_src"}, src_id, m_src);
        chk({tag, "_err"}, grant_err, m_err);
        chk({tag, "_to"}, timeout, m_to);
`ifdef PKT_CNT_EN
        chk({tag, "_cnt"}, pkt_cnt, m_cnt);
`endif
    endtask

    typedef struct {
        logic [15:0] grant, frame_n, valid_n, din;
        logic        e_frame, e_valid, e_dout, e_busy;
        logic [3:0]  e_src;
        logic        e_err, e_to;
    } vec_t;

    vec_t tbl[11];
    logic d5;

    initial begin
        // single packet on ch3, bad grant, IDLE beat ignored, grant withdrawn while armed
        tbl[0]  = '{16'h0008, 16'hFFFF, 16'hFFFF, 16'h0000, 1, 1, 0, 1, 3, 0, 0};
        tbl[1]  = '{16'h0008, 16'hFFF7, 16'hFFF7, 16'h0008, 0, 0, 1, 1, 3, 0, 0};
        tbl[2]  = '{16'h0008, 16'hFFF7, 16'hFFF7, 16'h0000, 0, 0, 0, 1, 3, 0, 0};
        tbl[3]  = '{16'h0008, 16'hFFF7, 16'hFFF7, 16'h0008, 0, 0, 1, 1, 3, 0, 0};
        tbl[4]  = '{16'h0008, 16'hFFFF, 16'hFFF7, 16'h0008, 1, 0, 1, 0, 0, 0, 0};
        tbl[5]  = '{16'h0000, 16'hFFFF, 16'hFFFF, 16'h0000, 1, 1, 0, 0, 0, 0, 0};
        tbl[6]  = '{16'h0005, 16'hFFFF, 16'hFFFF, 16'h0000, 1, 1, 0, 0, 0, 1, 0};
        tbl[7]  = '{16'h0000, 16'hFFFF, 16'hFFFF, 16'h0000, 1, 1, 0, 0, 0, 0, 0};
        tbl[8]  = '{16'h0000, 16'hFFFB, 16'hFFFB, 16'h0004, 1, 1, 0, 0, 0, 0, 0};
        tbl[9]  = '{16'h0002, 16'hFFFF, 16'hFFFF, 16'h0000, 1, 1, 0, 1, 1, 0, 0};
        tbl[10] = '{16'h0000, 16'hFFFF, 16'hFFFF, 16'h0000, 1, 1, 0, 0, 0, 0, 0};

        reset_n = 1'b0; grant = '0; frame_n = '1; valid_n = '1; din = '0;
        cyc(); cyc();
        chk("rst_frame", frame_o, 1'b1);
        chk("rst_valid", valid_o, 1'b1);
        chk("rst_dout", dout, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_src", src_id, 4'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            grant = tbl[i].grant; frame_n = tbl[i].frame_n;
            valid_n = tbl[i].valid_n; din = tbl[i].din;
            cyc();
            chk($sformatf("vec%0d_frame", i), frame_o, tbl[i].e_frame);
            chk($sformatf("vec%0d_valid", i), valid_o, tbl[i].e_valid);
            chk($sformatf("vec%0d_dout", i), dout, tbl[i].e_dout);
            chk($sformatf("vec%0d_busy", i), busy, tbl[i].e_busy);
            chk($sformatf("vec%0d_src", i), src_id, tbl[i].e_src);
            chk($sformatf("vec%0d_err", i), grant_err, tbl[i].e_err);
            chk($sformatf("vec%0d_to", i), timeout, tbl[i].e_to);
        end
`ifdef PKT_CNT_EN
        chk("vec_pkt_cnt", pkt_cnt, 16'd1);
`endif

        // timeout: pulse after exactly TO armed cycles, busy already low
        grant = 16'h0001; frame_n = '1;
        cyc();
        chk("to_busy_rise", busy, 1'b1);
        for (int i = 1; i < TO; i++) begin
            cyc();
            chk("to_early", timeout, 1'b0);
            chk("to_busy_hold", busy, 1'b1);
        end
        cyc();
        chk("to_pulse", timeout, 1'b1);
        chk("to_busy_drop", busy, 1'b0);
        chk("to_no_err", grant_err, 1'b0);
        grant = '0;
        cyc();
        chk("to_one_cycle", timeout, 1'b0);
`ifdef PKT_CNT_EN
        chk("to_pkt_cnt", pkt_cnt, 16'd1);
`endif

        // isolation: ch5 streams while ch4/ch6 toggle and the grant moves away
        grant = 16'h0020;
        cyc();
        cmp_model("iso_arm");
        for (int b = 0; b < 6; b++) begin
            d5 = 1'($urandom);
            frame_n = '1; valid_n = '1; din = $urandom;
            frame_n[4] = 1'($urandom); frame_n[6] = 1'($urandom);
            valid_n[4] = 1'($urandom); valid_n[6] = 1'($urandom);
            frame_n[5] = (b == 5); valid_n[5] = 1'b0; din[5] = d5;
            if (b == 1) grant = 16'h0001;
            cyc();
            chk("iso_dout", dout, d5);
            chk("iso_frame", frame_o, (b == 5));
            cmp_model("iso");
        end
        grant = '0; frame_n = '1; valid_n = '1; din = '0;
        cyc();
        cmp_model("iso_end");

        // reset during PASS beat 2 truncates the packet
        grant = 16'h0004;
        cyc();
        frame_n[2] = 1'b0; valid_n[2] = 1'b0; din[2] = 1'b1;
        cyc();
        chk("rstp_beat1", dout, 1'b1);
        reset_n = 1'b0;
        cyc();
        chk("rstp_frame", frame_o, 1'b1);
        chk("rstp_valid", valid_o, 1'b1);
        chk("rstp_dout", dout, 1'b0);
        chk("rstp_busy", busy, 1'b0);
        chk("rstp_src", src_id, 4'd0);
`ifdef PKT_CNT_EN
        chk("rstp_cnt", pkt_cnt, 16'd0);
`endif
        reset_n = 1'b1; grant = '0; frame_n = '1; valid_n = '1; din = '0;
        cyc();

        // back-to-back: ch15 then ch0 with the minimum gap
        grant = 16'h8000;
        cyc();
        chk("b2b_src15", src_id, 4'd15);
        frame_n[15] = 1'b0; valid_n[15] = 1'b0; din[15] = 1'b1;
        cyc();
        chk("b2b_a0", dout, 1'b1);
        frame_n[15] = 1'b1; din[15] = 1'b0;
        cyc();
        chk("b2b_a1_frame", frame_o, 1'b1);
        chk("b2b_a1_busy", busy, 1'b0);
        grant = 16'h0001; frame_n = '1; valid_n = '1; din = '0;
        cyc();
        chk("b2b_src0", src_id, 4'd0);
        chk("b2b_busy0", busy, 1'b1);
        chk("b2b_gap_frame", frame_o, 1'b1);
        frame_n[0] = 1'b0; valid_n[0] = 1'b0; din[0] = 1'b1;
        cyc();
        chk("b2b_b0", dout, 1'b1);
        chk("b2b_b0_frame", frame_o, 1'b0);
        frame_n[0] = 1'b1;
        cyc();
        cmp_model("b2b_b1");
        grant = '0; frame_n = '1; valid_n = '1; din = '0;
        cyc();
        cmp_model("b2b_end");

        // randomized traffic against the reference model
        for (int c = 0; c < 3000; c++) begin
            case ($urandom_range(0, 9))
                6:       grant = '0;
                7, 8:    grant = 16'h0001 << $urandom_range(0, 15);
                9:       grant = 16'($urandom);
                default: ;
            endcase
            frame_n = 16'($urandom);
            valid_n = 16'($urandom);
            din     = 16'($urandom);
            reset_n = ($urandom_range(0, 199) != 0);
            cyc();
            cmp_model("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
